// File: rtl/axi_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_pkg
// Shared constants for the AXI3 SRAM slave: burst type codes, response codes
// and the state encodings of the read and write engines. Also holds a small
// helper that decides whether a burst length is legal for WRAP addressing.
// ---------------------------------------------------------------------------
package axi_sram_slave_pkg;

  // AXI burst type codes (arburst/awburst)
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response codes (rresp/bresp)
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read engine states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Write engine states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // WRAP bursts only wrap for 2, 4, 8 or 16 beats; anything else is
  // handled as an incrementing burst.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// AXI3 bus bundle between a master (CPU/cache side) and the SRAM slave.
// Carries the AR, R, AW, W and B channels. Clock and reset are not part of
// the bundle.
//   master modport : drives AR/AW/W payloads and rready/bready
//   slave  modport : drives arready/awready/wready and the R/B payloads
// ---------------------------------------------------------------------------
interface axi_sram_slave_if;

  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  // Write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_sram_slave_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat byte address for one AXI burst.
//   addr      in  current beat byte address
//   start     in  first beat byte address of the burst (WRAP base source)
//   size      in  log2 bytes per beat
//   len       in  beats-1
//   burst     in  FIXED / INCR / WRAP
//   next_addr out byte address of the following beat
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_sram_slave_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] start,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] wrap_mask;
  logic [31:0] incr_addr;

  // The wrap window is (len+1) beats of 'step' bytes; its base is the start
  // address with the in-window bits cleared. Reserved burst code 11 and
  // illegal WRAP lengths fall through to plain incrementing.
  always_comb begin
    step      = 32'd1 << size;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    incr_addr = addr + step;
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      next_addr = (start & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3 slave with an internal word-organised SRAM (4 byte lanes). Separate
// read and write engines, each handling one outstanding burst, run fully
// concurrently. Supports FIXED/INCR/WRAP bursts, byte strobes and a
// configurable read latency.
//   aclk     in  clock
//   aresetn  in  synchronous active-low reset (memory contents are kept)
//   bus      slave modport of axi_sram_slave_if (AR, R, AW, W, B channels)
// Parameters:
//   MEM_AW   log2 of memory depth in 32-bit words; higher address bits alias
//   RD_LAT   cycles from AR handshake edge to first rvalid (>= 1)
// ---------------------------------------------------------------------------
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int RD_LAT = 2
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_sram_slave_if.slave bus
);

  localparam int         DEPTH        = 1 << MEM_AW;
  localparam logic [7:0] RD_WAIT_INIT = 8'(RD_LAT - 1);

  logic [3:0][7:0] mem [DEPTH];

  // Low during reset and for the reset edge itself, so the address ready
  // signals only come up the cycle after reset is released.
  logic alive;

  // Read engine state
  logic [1:0]  r_state;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [31:0] r_start;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic [31:0] r_data;
  logic [31:0] r_next;
  logic        ar_hs;
  logic        r_hs;
  logic        r_is_last;
  logic        rd_load;
  logic [31:0] rd_load_addr;

  // Write engine state
  logic [1:0]  w_state;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [31:0] w_start;
  logic [7:0]  w_len;
  logic [7:0]  w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [1:0]  b_resp;
  logic [31:0] w_next;
  logic        aw_hs;
  logic        w_hs;
  logic        w_at_len;

  logic unused_inputs;
  assign unused_inputs = ^{bus.arlock, bus.arcache, bus.arprot,
                           bus.awlock, bus.awcache, bus.awprot, bus.wid};

  // Reset-release tracker for arready/awready
  always_ff @(posedge aclk) begin
    if (!aresetn) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  // ---------------------------------------------------------------- read --
  assign ar_hs     = bus.arvalid && bus.arready;
  assign r_hs      = bus.rvalid && bus.rready;
  assign r_is_last = (r_beat == r_len);

  assign bus.arready = alive && (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_DATA);
  assign bus.rlast   = (r_state == R_DATA) && r_is_last;
  assign bus.rid     = r_id;
  assign bus.rdata   = r_data;
  assign bus.rresp   = RESP_OKAY;

  axi_burst_addr_gen u_rd_addr_gen (
    .addr      (r_addr),
    .start     (r_start),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  // rdata is a register that is only refreshed when a new beat is put on the
  // bus: on entry to R_DATA and after each accepted non-final beat. This is
  // what keeps rdata stable while the master stalls.
  always_comb begin
    rd_load      = 1'b0;
    rd_load_addr = r_addr;
    case (r_state)
      R_IDLE: begin
        if (ar_hs && (RD_LAT == 1)) begin
          rd_load      = 1'b1;
          rd_load_addr = bus.araddr;
        end
      end
      R_WAIT: begin
        if (r_cnt == 8'd1) rd_load = 1'b1;
      end
      R_DATA: begin
        if (r_hs && !r_is_last) begin
          rd_load      = 1'b1;
          rd_load_addr = r_next;
        end
      end
      default: ;
    endcase
  end

  // Read FSM: accept one AR, wait out the latency, then stream beats.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_id    <= 4'd0;
      r_addr  <= 32'd0;
      r_start <= 32'd0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_cnt   <= 8'd0;
      r_data  <= 32'd0;
    end else begin
      if (rd_load) r_data <= mem[rd_load_addr[MEM_AW+1:2]];
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_id    <= bus.arid;
            r_addr  <= bus.araddr;
            r_start <= bus.araddr;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_beat  <= 8'd0;
            r_cnt   <= RD_WAIT_INIT;
            r_state <= (RD_LAT == 1) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 8'd1) r_state <= R_DATA;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_is_last) begin
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write --
  assign aw_hs    = bus.awvalid && bus.awready;
  assign w_hs     = bus.wvalid && bus.wready;
  assign w_at_len = (w_beat == w_len);

  assign bus.awready = alive && (w_state == W_IDLE);
  assign bus.wready  = (w_state == W_DATA);
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bid     = w_id;
  assign bus.bresp   = b_resp;

  axi_burst_addr_gen u_wr_addr_gen (
    .addr      (w_addr),
    .start     (w_start),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  // Byte-lane memory write. No reset: contents survive aresetn. A read load
  // of the same word in the same cycle sees the pre-write value.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[w_addr[MEM_AW+1:2]][b] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: the burst closes on whichever comes first of wlast or the
  // final counted beat; only an exact match of both earns OKAY. Surplus
  // W beats are left unconsumed.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_id    <= 4'd0;
      w_addr  <= 32'd0;
      w_start <= 32'd0;
      w_len   <= 8'd0;
      w_beat  <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
      b_resp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_start <= bus.awaddr;
            w_len   <= bus.awlen;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
            w_beat  <= 8'd0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (bus.wlast || w_at_len) begin
              b_resp  <= (bus.wlast && w_at_len) ? RESP_OKAY : RESP_SLVERR;
              w_state <= W_RESP;
            end else begin
              w_addr <= w_next;
              w_beat <= w_beat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Self-checking bench for axi_sram_slave. Stimulus tasks push expected R
// beats and B responses (from a word-array memory model with closed-form
// burst addressing) into queues; independent monitors pop and compare
// whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int MEM_AW = 14;
  localparam int RD_LAT = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_sram_slave_if bus ();

  axi_sram_slave #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic [31:0] mdl [1 << MEM_AW];
  r_exp_t      rd_q [$];
  b_exp_t      b_q [$];
  logic [31:0] w_data_buf [16];
  logic [3:0]  w_strb_buf [16];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_hs_cnt = 0;
  logic rr_random = 1'b0;
  logic stall_mode = 1'b0;
  int stall_base = 0;
  int hold_cnt = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Byte address of beat i, straight from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input logic [1:0] burst, input int i);
    longint unsigned s, step, total, base;
    s = start;
    step = 64'd1 << size;
    total = step * longint'(len + 1);
    if (burst == BURST_FIXED) return start;
    if (burst == BURST_WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      base = s - (s % total);
      return 32'(base + ((s - base + longint'(i) * step) % total));
    end
    return 32'(s + longint'(i) * step);
  endfunction

  // R monitor
  always @(negedge aclk) begin
    r_exp_t e;
    if (aresetn && bus.rvalid && bus.rready) begin
      rd_hs_cnt++;
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL r_unexpected: got beat 0x%08h expected no beat", bus.rdata);
      end else begin
        e = rd_q.pop_front();
        check_output("rdata", bus.rdata, e.data);
        check_output("rlast", 32'(bus.rlast), 32'(e.last));
        check_output("rid", 32'(bus.rid), 32'(e.id));
        check_output("rresp", 32'(bus.rresp), 32'(RESP_OKAY));
      end
    end
  end

  // B monitor
  always @(negedge aclk) begin
    b_exp_t e;
    if (aresetn && bus.bvalid && bus.bready) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL b_unexpected: got bid %0d expected no response", bus.bid);
      end else begin
        e = b_q.pop_front();
        check_output("bid", 32'(bus.bid), 32'(e.id));
        check_output("bresp", 32'(bus.bresp), 32'(e.resp));
      end
    end
  end

  // rready/bready driver: always-ready, random backpressure, or a 5-cycle
  // hold on the second beat of the read being stalled.
  always begin
    @(posedge aclk);
    #1;
    if (stall_mode && rd_hs_cnt == stall_base + 1 && hold_cnt < 5) begin
      bus.rready = 1'b0;
      hold_cnt++;
    end else if (rr_random) begin
      bus.rready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.rready = 1'b1;
    end
    bus.bready = rr_random ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic apply_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, output int hs_cyc);
    logic [31:0] a;
    int t;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      rd_q.push_back('{data: mdl[a[MEM_AW+1:2]], last: (i == len), id: id});
    end
    bus.arid = id;
    bus.araddr = addr;
    bus.arlen = 8'(len);
    bus.arsize = 3'(size);
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (bus.arready) break;
      t++;
      if (t > 500) begin
        report_timeout("ar_handshake");
        break;
      end
    end
    hs_cyc = cyc;
    @(posedge aclk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  // Sends beats from w_data_buf/w_strb_buf; wlast is raised on beat wlast_at
  // (-1 for never). Only the beats the slave will consume are sent.
  task automatic apply_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst, input int wlast_at);
    logic [31:0] a;
    int nbeats;
    int t;
    nbeats = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
    for (int i = 0; i < nbeats; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      for (int b = 0; b < 4; b++) begin
        if (w_strb_buf[i][b]) mdl[a[MEM_AW+1:2]][8*b +: 8] = w_data_buf[i][8*b +: 8];
      end
    end
    b_q.push_back('{id: id, resp: (wlast_at == len) ? RESP_OKAY : RESP_SLVERR});
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = 8'(len);
    bus.awsize = 3'(size);
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (bus.awready) break;
      t++;
      if (t > 500) begin
        report_timeout("aw_handshake");
        break;
      end
    end
    @(posedge aclk);
    #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = w_data_buf[i];
      bus.wstrb = w_strb_buf[i];
      bus.wlast = (i == wlast_at);
      bus.wvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge aclk);
        if (bus.wready) break;
        t++;
        if (t > 500) begin
          report_timeout("w_handshake");
          break;
        end
      end
      @(posedge aclk);
      #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((rd_q.size() != 0 || b_q.size() != 0) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 3000) begin
      report_timeout("drain_queues");
      rd_q.delete();
      b_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_buf(input logic [31:0] base_val, input logic random_data);
    for (int i = 0; i < 16; i++) begin
      w_data_buf[i] = random_data ? $urandom : base_val + 32'(i);
      w_strb_buf[i] = 4'hf;
    end
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hc, t, len, size, idx;
    logic [1:0] burst;
    logic [31:0] addr, cap_data;
    logic [3:0] cap_id;
    logic cap_last;

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b1; bus.bready = 1'b1;
    for (int i = 0; i < (1 << MEM_AW); i++) mdl[i] = 32'hxxxx_xxxx;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_output("rst_arready", 32'(bus.arready), 0);
    check_output("rst_awready", 32'(bus.awready), 0);
    check_output("rst_rvalid", 32'(bus.rvalid), 0);
    check_output("rst_wready", 32'(bus.wready), 0);
    check_output("rst_bvalid", 32'(bus.bvalid), 0);
    check_output("rst_rdata", bus.rdata, 0);
    check_output("rst_bresp", 32'(bus.bresp), 0);
    check_output("rst_rlast", 32'(bus.rlast), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_output("rel_arready_first_edge", 32'(bus.arready), 0);
    @(negedge aclk);
    check_output("rel_arready", 32'(bus.arready), 1);
    check_output("rel_awready", 32'(bus.awready), 1);
    @(posedge aclk);
    #1;

    $display("[TB] preloading words 0..255");
    for (int k = 0; k < 16; k++) begin
      fill_buf(32'h0, 1'b1);
      apply_write(4'(k), 32'(k * 64), 15, 2, BURST_INCR, 15);
    end
    wait_idle();

    $display("[TB] INCR write then read at 0x1c000100");
    fill_buf(32'h0000_00A0, 1'b0);
    apply_write(4'h3, 32'h1c00_0100, 3, 2, BURST_INCR, 3);
    wait_idle();
    apply_read(4'h5, 32'h1c00_0100, 3, 2, BURST_INCR, hc);
    wait_idle();

    $display("[TB] byte strobe merge at 0x200");
    w_data_buf[0] = 32'h1122_3344; w_strb_buf[0] = 4'hf;
    apply_write(4'h1, 32'h0000_0200, 0, 2, BURST_INCR, 0);
    wait_idle();
    w_data_buf[0] = 32'hAABB_CCDD; w_strb_buf[0] = 4'b0101;
    apply_write(4'h2, 32'h0000_0200, 0, 2, BURST_INCR, 0);
    wait_idle();
    apply_read(4'h7, 32'h0000_0200, 0, 2, BURST_INCR, hc);
    wait_idle();

    $display("[TB] WRAP read from 0x108");
    fill_buf(32'hC0DE_0100, 1'b0);
    apply_write(4'h4, 32'h0000_0100, 3, 2, BURST_INCR, 3);
    wait_idle();
    apply_read(4'h8, 32'h0000_0108, 3, 2, BURST_WRAP, hc);
    wait_idle();

    $display("[TB] read latency and stall on beat 2");
    stall_base = rd_hs_cnt;
    hold_cnt = 0;
    stall_mode = 1'b1;
    apply_read(4'hA, 32'h0000_0040, 3, 2, BURST_INCR, hc);
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!bus.rvalid && t < 50);
    check_output("rd_latency", 32'(cyc - hc), 32'(RD_LAT));
    t = 0;
    while (!(rd_hs_cnt == stall_base + 1 && bus.rvalid && !bus.rready) && t < 50) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 50) report_timeout("stall_start");
    cap_data = bus.rdata;
    cap_last = bus.rlast;
    cap_id = bus.rid;
    repeat (4) begin
      @(negedge aclk);
      check_output("stall_rvalid", 32'(bus.rvalid), 1);
      check_output("stall_rdata", bus.rdata, cap_data);
      check_output("stall_rlast", 32'(bus.rlast), 32'(cap_last));
      check_output("stall_rid", 32'(bus.rid), 32'(cap_id));
    end
    wait_idle();
    stall_mode = 1'b0;

    $display("[TB] early wlast and missing wlast");
    fill_buf(32'hEE00_0000, 1'b0);
    apply_write(4'hB, 32'h0000_0280, 3, 2, BURST_INCR, 1);
    wait_idle();
    fill_buf(32'hDD00_0000, 1'b0);
    apply_write(4'hC, 32'h0000_02c0, 1, 2, BURST_INCR, -1);
    wait_idle();
    apply_read(4'hD, 32'h0000_0280, 3, 2, BURST_INCR, hc);
    wait_idle();
    apply_read(4'hE, 32'h0000_02c0, 1, 2, BURST_INCR, hc);
    wait_idle();

    $display("[TB] concurrent AR and AW");
    fill_buf(32'h5A5A_0000, 1'b0);
    fork
      apply_read(4'h9, 32'h0000_0300, 3, 2, BURST_INCR, hc);
      apply_write(4'h6, 32'h0000_0380, 3, 2, BURST_INCR, 3);
    join
    wait_idle();
    apply_read(4'h2, 32'h0000_0380, 3, 2, BURST_INCR, hc);
    wait_idle();

    $display("[TB] reset in the middle of an 8-beat read");
    stall_base = rd_hs_cnt;
    apply_read(4'h3, 32'h0000_0000, 7, 2, BURST_INCR, hc);
    t = 0;
    while (rd_hs_cnt < stall_base + 2 && t < 100) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 100) report_timeout("mid_burst");
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rd_q.delete();
    @(negedge aclk);
    check_output("midrst_rvalid", 32'(bus.rvalid), 0);
    check_output("midrst_arready", 32'(bus.arready), 0);
    check_output("midrst_bvalid", 32'(bus.bvalid), 0);
    @(negedge aclk);
    check_output("midrst_arready_rel", 32'(bus.arready), 1);
    check_output("midrst_awready_rel", 32'(bus.awready), 1);
    @(posedge aclk);
    #1;
    apply_read(4'h5, 32'h0000_0380, 3, 2, BURST_INCR, hc);
    wait_idle();
    apply_read(4'h6, 32'h0000_0200, 0, 2, BURST_INCR, hc);
    wait_idle();

    $display("[TB] randomized traffic with backpressure");
    rr_random = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = 1;
        2: len = 3;
        3: len = 7;
        4: len = 15;
        default: len = $urandom_range(0, 15);
      endcase
      size = $urandom_range(0, 2);
      burst = 2'($urandom_range(0, 2));
      idx = $urandom_range(0, 191);
      addr = {16'($urandom), 6'd0, 8'(idx), 2'd0};
      if (size == 0) addr[1:0] = 2'($urandom_range(0, 3));
      else if (size == 1) addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          w_data_buf[i] = $urandom;
          w_strb_buf[i] = 4'($urandom);
        end
        apply_write(4'($urandom), addr, len, size, burst, len);
      end else begin
        apply_read(4'($urandom), addr, len, size, burst, hc);
      end
      wait_idle();
    end
    rr_random = 1'b0;
    repeat (4) @(posedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
